// File: rtl/bitbrick_mac_seq_if.sv
// Operand-in / result-out stream bundle for the bitbrick MAC sequencer.
interface bitbrick_mac_seq_if #(parameter int ACC_W = 32);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_signed;
  logic [1:0]       in_prec;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_prec, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_prec, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bitbrick_mac_seq.sv
// Brick-serial MAC: walks 2-bit slice pairs of each operand pair through one
// external bitbrick, shifting and accumulating its products into a dot-product.
module bitbrick_mac_seq #(
  parameter int ACC_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  bitbrick_mac_seq_if.slave   bus,
  output logic [1:0]          bb_x,
  output logic                bb_sx,
  output logic [1:0]          bb_y,
  output logic                bb_sy,
  output logic                bb_shift,
  input  logic [9:0]          bb_prod
);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sgn;
    logic [1:0] prec;
    logic       last;
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [1:0]       i_q, j_q;
  logic [1:0]       s_max;
  logic [3:0]       shamt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] prod_sh;
  logic             j_wrap, step_done;

  // Highest slice index for the latched precision; 2'b11 behaves as 8-bit.
  always_comb begin
    case (op_q.prec)
      2'b00:   s_max = 2'd0;
      2'b01:   s_max = 2'd1;
      default: s_max = 2'd3;
    endcase
  end

  assign j_wrap    = (j_q == s_max);
  assign step_done = j_wrap && (i_q == s_max);
  assign shamt     = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
  assign prod_ext  = {{(ACC_W-10){bb_prod[9]}}, bb_prod};
  assign prod_sh   = prod_ext << shamt;
  assign bb_shift  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bb_x          = 2'b00;
    bb_y          = 2'b00;
    bb_sx         = 1'b0;
    bb_sy         = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        bb_x  = op_q.a[{i_q, 1'b0} +: 2];
        bb_y  = op_q.b[{j_q, 1'b0} +: 2];
        // Only the top slice of a signed operand carries the sign.
        bb_sx = op_q.sgn && (i_q == s_max);
        bb_sy = op_q.sgn && (j_q == s_max);
        if (step_done) state_nxt = op_q.last ? OUT : IDLE;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      i_q  <= 2'd0;
      j_q  <= 2'd0;
      acc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q <= '{a: bus.in_a, b: bus.in_b, sgn: bus.in_signed,
                      prec: bus.in_prec, last: bus.in_last};
            i_q  <= 2'd0;
            j_q  <= 2'd0;
          end
        end
        RUN: begin
          acc <= acc + prod_sh;
          // j runs fastest; i advances when j wraps.
          if (j_wrap) begin
            j_q <= 2'd0;
            if (!step_done) i_q <= i_q + 2'd1;
          end else begin
            j_q <= j_q + 2'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) acc <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitbrick_mac_seq.sv
// Directed bench for bitbrick_mac_seq with a behavioural bitbrick in the loop.
module tb_bitbrick_mac_seq;
  localparam int ACC_W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bb_x, bb_y;
  logic       bb_sx, bb_sy, bb_shift;
  logic [9:0] bb_prod;

  int n_vec = 0;
  int n_err = 0;

  bitbrick_mac_seq_if #(.ACC_W(ACC_W)) bus ();

  bitbrick_mac_seq #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .bb_x(bb_x), .bb_sx(bb_sx), .bb_y(bb_y), .bb_sy(bb_sy),
    .bb_shift(bb_shift), .bb_prod(bb_prod)
  );

  always #5 clk = ~clk;

  // Bitbrick reference: 2-bit x 2-bit, each side signed or unsigned.
  int xv, yv, pv;
  always_comb begin
    if (bb_sx) xv = $signed(bb_x);
    else       xv = int'(bb_x);
    if (bb_sy) yv = $signed(bb_y);
    else       yv = int'(bb_y);
    pv      = xv * yv;
    bb_prod = pv[9:0];
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [1:0]  prec;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2;
      2'b01:   return 5;
      default: return 17;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [1:0] p, input logic l);
    int t = 0;
    while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    bus.in_signed = s; bus.in_prec = p; bus.in_last = l;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counting the accept cycle as 0, out_valid must first appear in cycle lat.
  task automatic get_result(input logic [31:0] exp, input int lat, input string name);
    int c = 1;
    while (!bus.out_valid && c < 300) begin @(negedge clk); c++; end
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_lat"}, 32'(c), 32'(lat));
    chk({name, "_data"}, bus.out_data, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_drop"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vt[0]  = '{8'hFF, 8'hFF, 1'b0, 2'b10, 32'd65025};
    vt[1]  = '{8'h80, 8'h7F, 1'b1, 2'b10, 32'hFFFFC080};
    vt[2]  = '{8'hFE, 8'h02, 1'b1, 2'b00, 32'd4};
    vt[3]  = '{8'hAF, 8'h5F, 1'b0, 2'b01, 32'd225};
    vt[4]  = '{8'h08, 8'h07, 1'b1, 2'b01, 32'hFFFFFFC8};
    vt[5]  = '{8'h03, 8'h03, 1'b0, 2'b00, 32'd9};
    vt[6]  = '{8'hFF, 8'hFF, 1'b1, 2'b10, 32'd1};
    vt[7]  = '{8'h80, 8'h80, 1'b1, 2'b10, 32'd16384};
    vt[8]  = '{8'h80, 8'h02, 1'b0, 2'b10, 32'd256};
    vt[9]  = '{8'd200, 8'd3, 1'b0, 2'b11, 32'd600};
    vt[10] = '{8'h01, 8'h03, 1'b1, 2'b00, 32'hFFFFFFFF};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_signed = 1'b0;
    bus.in_prec = 2'b00; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_bb", {26'd0, bb_x, bb_sx, bb_y, bb_sy, bb_shift}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int k = 0; k < 11; k++) begin
      send_pair(vt[k].a, vt[k].b, vt[k].sgn, vt[k].prec, 1'b1);
      get_result(vt[k].exp, lat_of(vt[k].prec), $sformatf("vec%0d", k));
    end

    // Three-pair signed 4-bit stream: -56 + 9 + 1
    send_pair(8'h08, 8'h07, 1'b1, 2'b01, 1'b0);
    repeat (4) @(negedge clk);
    chk("strm_rdy1", 32'(bus.in_ready), 32'd1);
    chk("strm_nov1", 32'(bus.out_valid), 32'd0);
    send_pair(8'h03, 8'h03, 1'b1, 2'b01, 1'b0);
    repeat (4) @(negedge clk);
    chk("strm_rdy2", 32'(bus.in_ready), 32'd1);
    chk("strm_nov2", 32'(bus.out_valid), 32'd0);
    send_pair(8'h0F, 8'h0F, 1'b1, 2'b01, 1'b1);
    get_result(32'hFFFFFFD2, 5, "strm");

    // Backpressure: result must hold while out_ready stays low
    send_pair(8'h02, 8'h03, 1'b0, 2'b01, 1'b1);
    repeat (4) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", bus.out_data, 32'd6);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    get_result(32'd6, 1, "bp_rel");
    send_pair(8'h01, 8'h01, 1'b0, 2'b00, 1'b1);
    get_result(32'd1, 2, "bp_next");

    // Reset asserted during step 7 of an 8-bit pair
    send_pair(8'hFF, 8'hFF, 1'b0, 2'b10, 1'b1);
    repeat (7) @(negedge clk);
    chk("mid_bb_x", 32'(bb_x), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_bb", {26'd0, bb_x, bb_sx, bb_y, bb_sy, bb_shift}, 32'd0);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_out_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    send_pair(8'h0F, 8'h0F, 1'b0, 2'b01, 1'b1);
    get_result(32'd225, 5, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
